// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, two combinational read ports and one commit port.
// Optional RF_COMMIT_BYPASS_EN forwards a matching same-cycle commit onto the read ports.
module register_file #(
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 issue_ready,
    input  logic [4:0]           issue_rd_id,
    input  logic [ROB_WIDTH-1:0] issue_rob_index,
    input  logic [4:0]           iu_rs1_id,
    output logic [31:0]          rf_to_iu_val1,
    output logic [ROB_WIDTH-1:0] rf_to_iu_rs1_depend,
    input  logic [4:0]           iu_rs2_id,
    output logic [31:0]          rf_to_iu_val2,
    output logic [ROB_WIDTH-1:0] rf_to_iu_rs2_depend,
    input  logic                 rob_to_rf_ready,
    input  logic [4:0]           rob_to_rf_reg_id,
    input  logic [31:0]          rob_to_rf_reg_val,
    input  logic [ROB_WIDTH-1:0] rob_to_rf_rob_index
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    logic [NREG-1:0][XLEN-1:0]      val_q;
    logic [NREG-1:0][ROB_WIDTH-1:0] dep_q;

    logic commit_en;
    logic issue_en;

    assign commit_en = rdy_in & rob_to_rf_ready & (rob_to_rf_reg_id != 5'd0);
    assign issue_en  = rdy_in & issue_ready & ~clr_in & (issue_rd_id != 5'd0);

    // Later assignments win: flush clears every tag, a fresh issue tag overrides a commit clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            val_q <= '0;
            dep_q <= '0;
        end else begin
            if (commit_en) begin
                val_q[rob_to_rf_reg_id] <= rob_to_rf_reg_val;
                if (dep_q[rob_to_rf_reg_id] == rob_to_rf_rob_index) begin
                    dep_q[rob_to_rf_reg_id] <= '0;
                end
            end
            if (rdy_in && clr_in) begin
                dep_q <= '0;
            end
            if (issue_en) begin
                dep_q[issue_rd_id] <= issue_rob_index;
            end
        end
    end

    // Read port 1
    always_comb begin
        rf_to_iu_val1       = val_q[iu_rs1_id];
        rf_to_iu_rs1_depend = dep_q[iu_rs1_id];
        if (iu_rs1_id == 5'd0) begin
            rf_to_iu_val1       = '0;
            rf_to_iu_rs1_depend = '0;
        end
`ifdef RF_COMMIT_BYPASS_EN
        if (commit_en && (rob_to_rf_reg_id == iu_rs1_id) &&
            (dep_q[iu_rs1_id] == rob_to_rf_rob_index)) begin
            rf_to_iu_val1       = rob_to_rf_reg_val;
            rf_to_iu_rs1_depend = '0;
        end
`endif
    end

    // Read port 2
    always_comb begin
        rf_to_iu_val2       = val_q[iu_rs2_id];
        rf_to_iu_rs2_depend = dep_q[iu_rs2_id];
        if (iu_rs2_id == 5'd0) begin
            rf_to_iu_val2       = '0;
            rf_to_iu_rs2_depend = '0;
        end
`ifdef RF_COMMIT_BYPASS_EN
        if (commit_en && (rob_to_rf_reg_id == iu_rs2_id) &&
            (dep_q[iu_rs2_id] == rob_to_rf_rob_index)) begin
            rf_to_iu_val2       = rob_to_rf_reg_val;
            rf_to_iu_rs2_depend = '0;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against an array model.
module tb_register_file;

    localparam int unsigned RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clr_in;
    logic          issue_ready;
    logic [4:0]    issue_rd_id;
    logic [RW-1:0] issue_rob_index;
    logic [4:0]    iu_rs1_id;
    logic [31:0]   rf_to_iu_val1;
    logic [RW-1:0] rf_to_iu_rs1_depend;
    logic [4:0]    iu_rs2_id;
    logic [31:0]   rf_to_iu_val2;
    logic [RW-1:0] rf_to_iu_rs2_depend;
    logic          rob_to_rf_ready;
    logic [4:0]    rob_to_rf_reg_id;
    logic [31:0]   rob_to_rf_reg_val;
    logic [RW-1:0] rob_to_rf_rob_index;

    int errors = 0;
    int checks = 0;

    logic [31:0]   mval [32];
    logic [RW-1:0] mdep [32];

    register_file #(.ROB_WIDTH(RW)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .clr_in              (clr_in),
        .issue_ready         (issue_ready),
        .issue_rd_id         (issue_rd_id),
        .issue_rob_index     (issue_rob_index),
        .iu_rs1_id           (iu_rs1_id),
        .rf_to_iu_val1       (rf_to_iu_val1),
        .rf_to_iu_rs1_depend (rf_to_iu_rs1_depend),
        .iu_rs2_id           (iu_rs2_id),
        .rf_to_iu_val2       (rf_to_iu_val2),
        .rf_to_iu_rs2_depend (rf_to_iu_rs2_depend),
        .rob_to_rf_ready     (rob_to_rf_ready),
        .rob_to_rf_reg_id    (rob_to_rf_reg_id),
        .rob_to_rf_reg_val   (rob_to_rf_reg_val),
        .rob_to_rf_rob_index (rob_to_rf_rob_index)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic bypass_hit(input logic [4:0] id);
        bypass_hit = 1'b0;
`ifdef RF_COMMIT_BYPASS_EN
        bypass_hit = rdy_in && rob_to_rf_ready && (id != 5'd0) &&
                     (rob_to_rf_reg_id == id) && (mdep[id] == rob_to_rf_rob_index);
`endif
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] id);
        if (id == 5'd0) return 32'd0;
        if (bypass_hit(id)) return rob_to_rf_reg_val;
        return mval[id];
    endfunction

    function automatic logic [RW-1:0] exp_dep(input logic [4:0] id);
        if (id == 5'd0) return '0;
        if (bypass_hit(id)) return '0;
        return mdep[id];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mval[i] = 32'd0;
            mdep[i] = '0;
        end
    endtask

    // Next-state of the reference arrays from the inputs currently presented.
    task automatic model_update();
        logic [RW-1:0] nd [32];
        if (!rdy_in) return;
        nd = mdep;
        if (rob_to_rf_ready && rob_to_rf_reg_id != 5'd0) begin
            mval[rob_to_rf_reg_id] = rob_to_rf_reg_val;
            if (mdep[rob_to_rf_reg_id] == rob_to_rf_rob_index) nd[rob_to_rf_reg_id] = '0;
        end
        if (clr_in) begin
            for (int i = 0; i < 32; i++) nd[i] = '0;
        end else if (issue_ready && issue_rd_id != 5'd0) begin
            nd[issue_rd_id] = issue_rob_index;
        end
        mdep = nd;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in              = 1'b1;
        clr_in              = 1'b0;
        issue_ready         = 1'b0;
        issue_rd_id         = 5'd0;
        issue_rob_index     = '0;
        rob_to_rf_ready     = 1'b0;
        rob_to_rf_reg_id    = 5'd0;
        rob_to_rf_reg_val   = 32'd0;
        rob_to_rf_rob_index = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] idx);
        issue_ready = 1'b1; issue_rd_id = rd; issue_rob_index = idx;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [RW-1:0] idx);
        rob_to_rf_ready = 1'b1; rob_to_rf_reg_id = rd; rob_to_rf_reg_val = v; rob_to_rf_rob_index = idx;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        model_reset();
        iu_rs1_id = 5'd5;
        iu_rs2_id = 5'd0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        checks++; if (rf_to_iu_val1 !== 32'd0) begin errors++; $display("FAIL reset_val1 got=%h exp=0", rf_to_iu_val1); end
        checks++; if (rf_to_iu_rs1_depend !== '0) begin errors++; $display("FAIL reset_dep1 got=%0d exp=0", rf_to_iu_rs1_depend); end
        checks++; if (rf_to_iu_val2 !== 32'd0) begin errors++; $display("FAIL reset_val2 got=%h exp=0", rf_to_iu_val2); end
        checks++; if (rf_to_iu_rs2_depend !== '0) begin errors++; $display("FAIL reset_dep2 got=%0d exp=0", rf_to_iu_rs2_depend); end
    endtask

    task automatic test_issue_commit();
        idle(); issue(5'd5, 4'd3); tick();
        idle(); iu_rs1_id = 5'd5; #1;
        checks++; if (rf_to_iu_rs1_depend !== 4'd3) begin errors++; $display("FAIL issue_tag got=%0d exp=3", rf_to_iu_rs1_depend); end
        commit(5'd5, 32'h1234, 4'd3); tick();
        idle(); #1;
        checks++; if (rf_to_iu_val1 !== 32'h1234) begin errors++; $display("FAIL commit_val got=%h exp=1234", rf_to_iu_val1); end
        checks++; if (rf_to_iu_rs1_depend !== 4'd0) begin errors++; $display("FAIL commit_clear got=%0d exp=0", rf_to_iu_rs1_depend); end
    endtask

    task automatic test_stale_commit();
        idle(); issue(5'd5, 4'd3); tick();
        idle(); issue(5'd5, 4'd4); tick();
        idle(); commit(5'd5, 32'd7, 4'd3); tick();
        idle(); iu_rs2_id = 5'd5; #1;
        checks++; if (rf_to_iu_val2 !== 32'd7) begin errors++; $display("FAIL stale_val got=%h exp=7", rf_to_iu_val2); end
        checks++; if (rf_to_iu_rs2_depend !== 4'd4) begin errors++; $display("FAIL stale_keep_tag got=%0d exp=4", rf_to_iu_rs2_depend); end
    endtask

    task automatic test_issue_commit_same_cycle();
        idle(); issue(5'd5, 4'd3); tick();
        idle(); commit(5'd5, 32'd9, 4'd3); issue(5'd5, 4'd6); tick();
        idle(); iu_rs1_id = 5'd5; #1;
        checks++; if (rf_to_iu_val1 !== 32'd9) begin errors++; $display("FAIL same_cycle_val got=%h exp=9", rf_to_iu_val1); end
        checks++; if (rf_to_iu_rs1_depend !== 4'd6) begin errors++; $display("FAIL same_cycle_tag got=%0d exp=6", rf_to_iu_rs1_depend); end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            idle(); issue(5'(r), 4'(r)); tick();
        end
        idle(); clr_in = 1'b1; commit(5'd2, 32'hAA, 4'd2); issue(5'd7, 4'd5); tick();
        idle();
        for (int r = 1; r <= 4; r++) begin
            iu_rs1_id = 5'(r); #1;
            checks++; if (rf_to_iu_rs1_depend !== 4'd0) begin errors++; $display("FAIL flush_tag x%0d got=%0d exp=0", r, rf_to_iu_rs1_depend); end
        end
        iu_rs1_id = 5'd2; iu_rs2_id = 5'd7; #1;
        checks++; if (rf_to_iu_val1 !== 32'hAA) begin errors++; $display("FAIL flush_commit_val got=%h exp=aa", rf_to_iu_val1); end
        checks++; if (rf_to_iu_rs2_depend !== 4'd0) begin errors++; $display("FAIL flush_issue_ignored got=%0d exp=0", rf_to_iu_rs2_depend); end
    endtask

    task automatic test_x0();
        idle(); commit(5'd0, 32'hDEAD, 4'd1); issue(5'd0, 4'd2); tick();
        idle(); iu_rs1_id = 5'd0; iu_rs2_id = 5'd0; #1;
        checks++; if (rf_to_iu_val1 !== 32'd0) begin errors++; $display("FAIL x0_val got=%h exp=0", rf_to_iu_val1); end
        checks++; if (rf_to_iu_rs2_depend !== 4'd0) begin errors++; $display("FAIL x0_dep got=%0d exp=0", rf_to_iu_rs2_depend); end
    endtask

    task automatic test_bypass();
        logic [31:0]   old_val;
        logic [31:0]   want_val;
        logic [RW-1:0] want_dep;
        idle(); issue(5'd5, 4'd3); tick();
        old_val = mval[5];
        idle(); commit(5'd5, 32'h55, 4'd3); iu_rs1_id = 5'd5; iu_rs2_id = 5'd5; #1;
`ifdef RF_COMMIT_BYPASS_EN
        want_val = 32'h55; want_dep = 4'd0;
`else
        want_val = old_val; want_dep = 4'd3;
`endif
        checks++; if (rf_to_iu_val1 !== want_val) begin errors++; $display("FAIL bypass_val1 got=%h exp=%h", rf_to_iu_val1, want_val); end
        checks++; if (rf_to_iu_rs2_depend !== want_dep) begin errors++; $display("FAIL bypass_dep2 got=%0d exp=%0d", rf_to_iu_rs2_depend, want_dep); end
        tick();
        idle(); #1;
        checks++; if (rf_to_iu_val2 !== 32'h55) begin errors++; $display("FAIL post_commit_val got=%h exp=55", rf_to_iu_val2); end
        checks++; if (rf_to_iu_rs1_depend !== 4'd0) begin errors++; $display("FAIL post_commit_dep got=%0d exp=0", rf_to_iu_rs1_depend); end
    endtask

    task automatic test_hold();
        idle(); issue(5'd9, 4'd2); tick();
        idle(); rdy_in = 1'b0; clr_in = 1'b1; issue(5'd10, 4'd5); commit(5'd9, 32'hBEEF, 4'd2); tick();
        idle(); iu_rs1_id = 5'd9; iu_rs2_id = 5'd10; #1;
        checks++; if (rf_to_iu_rs1_depend !== 4'd2) begin errors++; $display("FAIL hold_tag got=%0d exp=2", rf_to_iu_rs1_depend); end
        checks++; if (rf_to_iu_val1 !== 32'd0) begin errors++; $display("FAIL hold_val got=%h exp=0", rf_to_iu_val1); end
        checks++; if (rf_to_iu_rs2_depend !== 4'd0) begin errors++; $display("FAIL hold_issue got=%0d exp=0", rf_to_iu_rs2_depend); end
    endtask

    task automatic test_mid_reset();
        idle(); issue(5'd12, 4'd7); commit(5'd13, 32'h77, 4'd1); tick();
        idle(); iu_rs1_id = 5'd12; iu_rs2_id = 5'd13; #2;
        rst_in = 1'b1;
        model_reset();
        #1;
        checks++; if (rf_to_iu_rs1_depend !== 4'd0) begin errors++; $display("FAIL midreset_tag got=%0d exp=0", rf_to_iu_rs1_depend); end
        checks++; if (rf_to_iu_val2 !== 32'd0) begin errors++; $display("FAIL midreset_val got=%h exp=0", rf_to_iu_val2); end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] cid;
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            clr_in = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 7)), 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 2) != 0) begin
                cid = 5'($urandom_range(0, 7));
                commit(cid, $urandom, ($urandom_range(0, 9) < 7) ? mdep[cid] : 4'($urandom_range(1, 15)));
            end
            iu_rs1_id = 5'($urandom_range(0, 7));
            iu_rs2_id = ($urandom_range(0, 1) == 1) ? rob_to_rf_reg_id : 5'($urandom_range(0, 31));
            #1;
            checks++; if (rf_to_iu_val1 !== exp_val(iu_rs1_id)) begin errors++; $display("FAIL rand_val1 n=%0d x%0d got=%h exp=%h", n, iu_rs1_id, rf_to_iu_val1, exp_val(iu_rs1_id)); end
            checks++; if (rf_to_iu_rs1_depend !== exp_dep(iu_rs1_id)) begin errors++; $display("FAIL rand_dep1 n=%0d x%0d got=%0d exp=%0d", n, iu_rs1_id, rf_to_iu_rs1_depend, exp_dep(iu_rs1_id)); end
            checks++; if (rf_to_iu_val2 !== exp_val(iu_rs2_id)) begin errors++; $display("FAIL rand_val2 n=%0d x%0d got=%h exp=%h", n, iu_rs2_id, rf_to_iu_val2, exp_val(iu_rs2_id)); end
            checks++; if (rf_to_iu_rs2_depend !== exp_dep(iu_rs2_id)) begin errors++; $display("FAIL rand_dep2 n=%0d x%0d got=%0d exp=%0d", n, iu_rs2_id, rf_to_iu_rs2_depend, exp_dep(iu_rs2_id)); end
            tick();
        end
    endtask

    initial begin
        rst_in = 1'b1;
        iu_rs1_id = 5'd0;
        iu_rs2_id = 5'd0;
        idle();
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_issue_commit_same_cycle();
        test_flush();
        test_x0();
        test_bypass();
        test_hold();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
